clock_display: RTL

CLOCK_DISPLAY -- requirements
Module: clock_display

---
 rtl/clock_disp_pkg.sv | 35 +++
 rtl/seg7_decode.sv | 26 ++
 rtl/clock_display.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/clock_disp_pkg.sv
// rtl/clock_disp_pkg.sv - shared types, digit count and seven-segment codes for clock_display
package clock_disp_pkg;

  localparam int NUM_DIGITS = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_t;

  // Active-low patterns, bit 0 = segment a .. bit 6 = segment g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Double-dabble correction applied to a two-nibble BCD field before each shift
  function automatic logic [7:0] bcd_adjust(input logic [7:0] b);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = (b[3:0] >= 4'd5) ? b[3:0] + 4'd3 : b[3:0];
    hi = (b[7:4] >= 4'd5) ? b[7:4] + 4'd3 : b[7:4];
    return {hi, lo};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational 4-bit BCD to active-low seven-segment pattern
module seg7_decode
  import clock_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_display.sv
// rtl/clock_display.sv - six-digit multiplexed hh.mm.ss display with per-frame BCD conversion
module clock_display
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hrs,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       bcd_valid
);

  localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [2:0]  LAST_DIGIT = 3'(NUM_DIGITS - 1);

  logic [15:0] r_scan_cnt;
  logic [2:0]  r_digit_idx;
  logic        r_first;

  logic [4:0]  r_snap_hrs;
  logic [5:0]  r_snap_min;
  logic [5:0]  r_snap_sec;

  conv_state_t r_state;
  logic [2:0]  r_shift_cnt;
  logic [7:0]  r_bcd_h;
  logic [7:0]  r_bcd_m;
  logic [7:0]  r_bcd_s;
  logic [5:0]  r_bin_h;
  logic [5:0]  r_bin_m;
  logic [5:0]  r_bin_s;
  logic [NUM_DIGITS-1:0][3:0] r_disp;
  logic        r_bcd_valid;

  logic [6:0]  r_seg;
  logic [5:0]  r_an;
  logic        r_dp;

  logic        w_term;
  logic        w_wrap;
  logic        w_snap_take;
  logic [7:0]  w_adj_h;
  logic [7:0]  w_adj_m;
  logic [7:0]  w_adj_s;
  logic [3:0]  w_cur_bcd;
  logic [6:0]  w_seg;

  assign w_term = (r_scan_cnt == SCAN_LAST);
  assign w_wrap = w_term && (r_digit_idx == LAST_DIGIT);
  // A snapshot arriving while a conversion is still running is dropped
  assign w_snap_take = (r_first || w_wrap) && (r_state == ST_IDLE);

  assign w_adj_h = bcd_adjust(r_bcd_h);
  assign w_adj_m = bcd_adjust(r_bcd_m);
  assign w_adj_s = bcd_adjust(r_bcd_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt  <= 16'd0;
      r_digit_idx <= 3'd0;
      r_first     <= 1'b1;
    end else begin
      r_first <= 1'b0;
      if (w_term) begin
        r_scan_cnt  <= 16'd0;
        r_digit_idx <= (r_digit_idx == LAST_DIGIT) ? 3'd0 : r_digit_idx + 3'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_hrs <= 5'd0;
      r_snap_min <= 6'd0;
      r_snap_sec <= 6'd0;
    end else if (w_snap_take) begin
      r_snap_hrs <= hrs;
      r_snap_min <= min;
      r_snap_sec <= sec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shift_cnt <= 3'd0;
      r_bcd_h     <= 8'd0;
      r_bcd_m     <= 8'd0;
      r_bcd_s     <= 8'd0;
      r_bin_h     <= 6'd0;
      r_bin_m     <= 6'd0;
      r_bin_s     <= 6'd0;
      r_disp      <= '0;
      r_bcd_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_snap_take) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_bcd_h     <= 8'd0;
          r_bcd_m     <= 8'd0;
          r_bcd_s     <= 8'd0;
          r_bin_h     <= {1'b0, r_snap_hrs};
          r_bin_m     <= r_snap_min;
          r_bin_s     <= r_snap_sec;
          r_shift_cnt <= 3'd0;
          r_state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_bcd_h     <= {w_adj_h[6:0], r_bin_h[5]};
          r_bcd_m     <= {w_adj_m[6:0], r_bin_m[5]};
          r_bcd_s     <= {w_adj_s[6:0], r_bin_s[5]};
          r_bin_h     <= {r_bin_h[4:0], 1'b0};
          r_bin_m     <= {r_bin_m[4:0], 1'b0};
          r_bin_s     <= {r_bin_s[4:0], 1'b0};
          r_shift_cnt <= r_shift_cnt + 3'd1;
          if (r_shift_cnt == 3'd5) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          // All six digits land together so a frame never mixes old and new time
          r_disp[0]   <= r_bcd_s[3:0];
          r_disp[1]   <= r_bcd_s[7:4];
          r_disp[2]   <= r_bcd_m[3:0];
          r_disp[3]   <= r_bcd_m[7:4];
          r_disp[4]   <= r_bcd_h[3:0];
          r_disp[5]   <= r_bcd_h[7:4];
          r_bcd_valid <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cur_bcd = 4'd0;
    case (r_digit_idx)
      3'd0:    w_cur_bcd = r_disp[0];
      3'd1:    w_cur_bcd = r_disp[1];
      3'd2:    w_cur_bcd = r_disp[2];
      3'd3:    w_cur_bcd = r_disp[3];
      3'd4:    w_cur_bcd = r_disp[4];
      3'd5:    w_cur_bcd = r_disp[5];
      default: w_cur_bcd = 4'd0;
    endcase
  end

  seg7_decode u_seg7_decode (
    .i_bcd (w_cur_bcd),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= SEG_BLANK;
      r_an  <= 6'h3F;
      r_dp  <= 1'b1;
    end else if (r_bcd_valid) begin
      r_seg <= w_seg;
      r_an  <= ~(6'b000001 << r_digit_idx);
      r_dp  <= !((r_digit_idx == 3'd2) || (r_digit_idx == 3'd4));
    end else begin
      r_seg <= SEG_BLANK;
      r_an  <= 6'h3F;
      r_dp  <= 1'b1;
    end
  end

  assign seg       = r_seg;
  assign an        = r_an;
  assign dp        = r_dp;
  assign bcd_valid = r_bcd_valid;

endmodule
